// File: rtl/cell_shifter_pipe_pkg.sv
// Shared CLB constants: 3-bit opcodes used by the shifter cell and its siblings.
package cell_shifter_pipe_pkg;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_OR  = 3'd7;

endpackage

// File: rtl/cell_shifter_pipe_shift_op_unit.sv
// Combinational shift/logic evaluator; the shift amount is the low SH_W bits of b.
module shift_op_unit
  import cell_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  logic [SH_W-1:0] sh;
  logic [SH_W:0]   inv_sh;

  assign sh = b[SH_W-1:0];
  // Complementary shift for rotates; sh=0 gives a shift by WIDTH, which yields zero.
  assign inv_sh = (SH_W+1)'(WIDTH) - (SH_W+1)'(sh);

  always_comb begin
    result = '0;
    case (op)
      OP_SLL:  result = a << sh;
      OP_SRL:  result = a >> sh;
      OP_SRA:  result = $unsigned($signed(a) >>> sh);
      OP_XOR:  result = a ^ b;
      OP_ROL:  result = (a << sh) | (a >> inv_sh);
      OP_ROR:  result = (a >> sh) | (a << inv_sh);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cell_shifter_pipe.sv
// Two-stage shifter cell: S1 registers the selected operands, S2 registers the result.
module cell_shifter_pipe
  import cell_shifter_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN),
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel0,
  input  logic [SEL_W-1:0]        sel1,
  input  logic [2:0]              selOp,
  input  logic                    byPass,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             op_count
);

  logic [WIDTH-1:0] chan [NUM_IN];
  logic [WIDTH-1:0] a_sel, b_sel;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_op;
  logic             s1_bypass;

  logic [WIDTH-1:0] op_result;
  logic             s2_advance;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
    assign chan[k] = in_bus[k*WIDTH +: WIDTH];
  end

  assign a_sel = chan[sel0];
  assign b_sel = chan[sel1];

  // S1 may refill in the same cycle S2 drains, so a full pipe still streams.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_SLL;
      s1_bypass <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a_sel;
        s1_b      <= b_sel;
        s1_op     <= selOp;
        s1_bypass <= byPass;
      end
    end
  end

  shift_op_unit #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_op (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (op_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= s1_bypass ? s1_a : op_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cell_shifter_pipe.sv
// Directed self-checking bench for cell_shifter_pipe at WIDTH=32, NUM_IN=8.
module tb_cell_shifter_pipe;
  import cell_shifter_pipe_pkg::*;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              sel0, sel1;
  logic [2:0]              selOp;
  logic                    byPass;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             op_count;

  int checks   = 0;
  int failures = 0;

  cell_shifter_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel0      (sel0),
    .sel1      (sel1),
    .selOp     (selOp),
    .byPass    (byPass),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    in_bus[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic set_req(input logic [2:0] s0, input logic [2:0] s1,
                         input logic [2:0] op, input logic byp);
    sel0   = s0;
    sel1   = s1;
    selOp  = op;
    byPass = byp;
  endtask

  task automatic pulse_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // One request, observe two cycles after acceptance, then let it be consumed.
  task automatic issue_and_wait(output logic v, output logic [31:0] o);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    v = out_valid;
    o = out;
    cycle();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_bus    = '1;
    set_req(3'd0, 3'd1, OP_OR, 1'b0);
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid);
    end
    checks++;
    if (out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_out actual=%h required=00000000", out);
    end
    checks++;
    if (op_count !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_op_count actual=%h required=0000", op_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    cycle();
    cycle();
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ignores_in_valid actual=%b required=0", out_valid);
    end
  endtask

  task automatic test_sra();
    logic v;
    logic [31:0] o;
    pulse_reset();
    in_bus = '0;
    set_ch(2, 32'h80000001);
    set_ch(5, 32'h00000004);
    set_req(3'd2, 3'd5, OP_SRA, 1'b0);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'hF8000000) begin
      failures++;
      $display("[TB] FAIL sra_latency valid=%b out=%h required valid=1 out=f8000000", v, o);
    end
    checks++;
    if (op_count !== 16'd1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sra_consumed op_count=%h valid=%b required op_count=0001 valid=0",
               op_count, out_valid);
    end
  endtask

  task automatic test_rotate();
    logic v;
    logic [31:0] o;
    set_ch(0, 32'h12345678);
    set_ch(1, 32'h00000024);
    set_req(3'd0, 3'd1, OP_ROL, 1'b0);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'h23456781) begin
      failures++;
      $display("[TB] FAIL rol_4 valid=%b out=%h required valid=1 out=23456781", v, o);
    end
    set_req(3'd0, 3'd1, OP_ROR, 1'b0);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'h81234567) begin
      failures++;
      $display("[TB] FAIL ror_4 valid=%b out=%h required valid=1 out=81234567", v, o);
    end
  endtask

  // Operand a on channel 3, operand b on channel 6.
  task automatic test_ops();
    logic [2:0]  t_op  [11] = '{OP_SLL, OP_SRL, OP_SRA, OP_XOR, OP_AND, OP_OR,
                                OP_SLL, OP_ROL, OP_SRA, OP_ROR, OP_SRA};
    logic [31:0] t_a   [11] = '{32'h000000F1, 32'hF0000000, 32'h70000000, 32'hFF00FF00,
                                32'hFF00FF00, 32'hFF00FF00, 32'h00000001, 32'hCAFEBABE,
                                32'h80000000, 32'h00000001, 32'h80000000};
    logic [31:0] t_b   [11] = '{32'h00000008, 32'h0000001C, 32'h00000004, 32'h0F0F0F0F,
                                32'h0F0F0F0F, 32'h0F0F0F0F, 32'hFFFFFFE3, 32'h00000020,
                                32'h00000040, 32'h0000001F, 32'h0000001F};
    logic [31:0] t_exp [11] = '{32'h0000F100, 32'h0000000F, 32'h07000000, 32'hF00FF00F,
                                32'h0F000F00, 32'hFF0FFF0F, 32'h00000008, 32'hCAFEBABE,
                                32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    logic v;
    logic [31:0] o;
    for (int i = 0; i < 11; i++) begin
      set_ch(3, t_a[i]);
      set_ch(6, t_b[i]);
      set_req(3'd3, 3'd6, t_op[i], 1'b0);
      issue_and_wait(v, o);
      checks++;
      if (v !== 1'b1 || o !== t_exp[i]) begin
        failures++;
        $display("[TB] FAIL op_vec%0d op=%0d valid=%b out=%h required valid=1 out=%h",
                 i, t_op[i], v, o, t_exp[i]);
      end
    end
  endtask

  task automatic test_same_channel();
    logic v;
    logic [31:0] o;
    set_ch(4, 32'h00000003);
    set_req(3'd4, 3'd4, OP_SLL, 1'b0);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'h00000018) begin
      failures++;
      $display("[TB] FAIL same_ch_sll valid=%b out=%h required valid=1 out=00000018", v, o);
    end
    set_req(3'd4, 3'd4, OP_XOR, 1'b0);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'h00000000) begin
      failures++;
      $display("[TB] FAIL same_ch_xor valid=%b out=%h required valid=1 out=00000000", v, o);
    end
  endtask

  task automatic test_bypass();
    logic v;
    logic [31:0] o;
    set_ch(7, 32'hDEADBEEF);
    set_ch(0, 32'h0F0F0F0F);
    set_req(3'd7, 3'd0, OP_XOR, 1'b1);
    issue_and_wait(v, o);
    checks++;
    if (v !== 1'b1 || o !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL bypass valid=%b out=%h required valid=1 out=deadbeef", v, o);
    end
  endtask

  // Four back-to-back requests with the consumer stalled during cycles 3..6.
  task automatic test_back_to_back();
    logic [31:0] a_q   [4] = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
    logic [31:0] exp_q [4] = '{32'h111100FF, 32'h222200FF, 32'h333300FF, 32'h444400FF};
    int sent = 0;
    int got  = 0;
    pulse_reset();
    set_ch(1, 32'h000000FF);
    set_req(3'd0, 3'd1, OP_XOR, 1'b0);
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (sent < 4) begin
        in_valid = 1'b1;
        set_ch(0, a_q[sent]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 3 || c == 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_stall_in_ready cycle=%0d actual=%b required=0", c, in_ready);
        end
      end
      if (c == 7) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b_release_in_ready actual=%b required=1", in_ready);
        end
      end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || out !== exp_q[1]) begin
          failures++;
          $display("[TB] FAIL b2b_hold cycle=%0d valid=%b out=%h required valid=1 out=%h",
                   c, out_valid, out, exp_q[1]);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (got < 4) begin
          checks++;
          if (out !== exp_q[got]) begin
            failures++;
            $display("[TB] FAIL b2b_order idx=%0d actual=%h required=%h", got, out, exp_q[got]);
          end
        end
        got++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      failures++;
      $display("[TB] FAIL b2b_count actual=%0d required=4", got);
    end
  endtask

  task automatic test_reset_midflight();
    bit stale = 1'b0;
    set_ch(0, 32'h00000055);
    set_ch(1, 32'h00000001);
    set_req(3'd0, 3'd1, OP_SLL, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cycle();
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out !== 32'h0 || op_count !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midflight_reset valid=%b out=%h op_count=%h required 0/00000000/0000",
               out_valid, out, op_count);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      failures++;
      $display("[TB] FAIL midflight_stale actual=1 required=0");
    end
  endtask

  task automatic test_op_count_wrap();
    pulse_reset();
    set_ch(0, 32'h00000001);
    set_req(3'd0, 3'd0, OP_OR, 1'b1);
    in_valid = 1'b1;
    repeat (65537) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (op_count !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL op_count_wrap actual=%h required=0001", op_count);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bus    = '0;
    set_req(3'd0, 3'd0, OP_SLL, 1'b0);
    test_reset();
    test_sra();
    test_rotate();
    test_ops();
    test_same_channel();
    test_bypass();
    test_back_to_back();
    test_reset_midflight();
    test_op_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_shifter_pipe.md
CELL_SHIFTER_PIPE -- requirements
Module: cell_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal range 8..64, power of two.
REQ-002 SHALL have parameter NUM_IN, default 8, number of input channels; legal range 2..16, power of two.
REQ-003 SHALL have derived localparam SEL_W = clog2(NUM_IN) and SH_W = clog2(WIDTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_bus  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  1  request present on in_bus/sel0/sel1/selOp/byPass.
REQ-008 in_ready  output  1  block accepts request this cycle.
REQ-009 sel0  input  SEL_W  channel selected as operand0.
REQ-010 sel1  input  SEL_W  channel selected as operand1 (shift amount or second term).
REQ-011 selOp  input  3  operation select.
REQ-012 byPass  input  1  result = operand0, selOp ignored.
REQ-013 out  output  WIDTH  registered result.
REQ-014 out_valid  output  1  out holds a valid result.
REQ-015 out_ready  input  1  consumer accepts out this cycle.
REQ-016 op_count  output  16  number of results consumed since reset.

Function
REQ-017 A request SHALL be accepted when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-018 Pipeline SHALL have two register stages: S1 captures operand0, operand1, selOp, byPass; S2 captures computed result.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no backpressure; throughput one result per cycle.
REQ-020 in_ready SHALL equal !S1_valid || S2_advance, where S2_advance = !out_valid || out_ready (combinational, no bubble).
REQ-021 Under out_ready=0 SHALL hold out and all stage contents stable; no request lost or duplicated.
REQ-022 Operations on operand0 (a) and operand1 (b), sh = b[SH_W-1:0]: 0 SLL a<<sh; 1 SRL a>>sh; 2 SRA arithmetic right; 3 XOR a^b; 4 ROL; 5 ROR; 6 AND; 7 OR.
REQ-023 Shift amount SHALL use only the low SH_W bits of operand1; upper bits ignored; sh=0 returns a unchanged for ops 0,1,2,4,5.
REQ-024 sel0 == sel1 SHALL be legal; both operands take the same channel.
REQ-025 byPass=1 SHALL produce out = operand0 with same latency and handshake as any op.
REQ-026 Simultaneous accept and consume SHALL both occur in the same cycle.
REQ-027 op_count SHALL increment by 1 per consumed result and wrap from 0xFFFF to 0x0000.
REQ-028 Inputs other than in_valid SHALL be don't-care when not accepted.

Reset
REQ-029 On rst=1 at a clock edge: S1_valid=0, out_valid=0, out=0, op_count=0; in_ready=1 in the following cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight requests; no result emerges afterward for them.
REQ-031 in_valid during rst SHALL be ignored (not accepted).

Structure
REQ-032 Opcode constants OP_SLL..OP_OR (3-bit) SHALL live in the shared CLB constants package/include, reused by other cells.
REQ-033 Combinational op evaluation SHALL be one sub-module shift_op_unit (parameter WIDTH; ports a, b, op, result).
REQ-034 Channel selection SHALL be a parametrised NUM_IN-to-1 mux; no latches; S1/S2 registers only.

Verification
REQ-035 WIDTH=32,NUM_IN=8: ch2=0x80000001, ch5=0x00000004, sel0=2, sel1=5, selOp=2 -> out=0xF8000000 two cycles later, out_valid=1.
REQ-036 ch0=0x12345678, ch1=0x00000024 (sh=4), selOp=4 -> out=0x23456781; selOp=5 -> out=0x81234567.
REQ-037 Back-to-back 4 requests, out_ready=0 for cycles 3-6 -> in_ready=0 once S1 and S2 full; out stable; results emerge in order, none lost.
REQ-038 byPass=1, sel0=7, ch7=0xDEADBEEF, selOp=3 -> out=0xDEADBEEF.
REQ-039 Two requests in flight, rst pulsed one cycle -> out_valid=0, out=0, op_count=0, no stale results afterward.
REQ-040 Consume 65537 results -> op_count=0x0001.
